// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter: fetch vs. loader/debug, loader lock, NOP for out-of-range reads.
// Optional macro IMEM_ARB_PERF_EN adds saturating grant/stall performance counters.
module imem_arbiter #(
   parameter int ALEN         = 32,
   parameter int XLEN         = 32,
   parameter int DEPTH        = 1024,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [ALEN-1:0] if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [XLEN-1:0] if_rdata,
   input  logic            ld_req,
   input  logic            ld_we,
   input  logic [ALEN-1:0] ld_addr,
   input  logic [XLEN-1:0] ld_wdata,
   input  logic            ld_lock,
   output logic            ld_gnt,
   output logic            ld_rvalid,
   output logic [XLEN-1:0] ld_rdata,
   output logic            locked,
   output logic            mem_en,
   output logic            mem_we,
   output logic [ALEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
`ifdef IMEM_ARB_PERF_EN
   ,
   output logic [31:0]     perf_if_grants,
   output logic [31:0]     perf_ld_grants,
   output logic [31:0]     perf_if_stall
`endif
);

   typedef enum logic {ST_ARB, ST_LOCK} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_t;

   localparam logic [XLEN-1:0] NOP_INSN = XLEN'(32'h0000_0013);
   localparam logic [3:0]      LIMIT    = 4'(STARVE_LIMIT);

   state_t          state_r;
   owner_t          owner_r;
   logic            oor_r;
   logic            wr_r;
   logic [3:0]      starve_r;

   logic            if_gnt_s;
   logic            ld_gnt_s;
   logic [ALEN-1:0] if_word_s;
   logic [ALEN-1:0] ld_word_s;
   logic            if_inr_s;
   logic            ld_inr_s;

   assign if_word_s = if_addr >> 2;
   assign ld_word_s = ld_addr >> 2;
   assign if_inr_s  = (if_word_s < ALEN'(DEPTH));
   assign ld_inr_s  = (ld_word_s < ALEN'(DEPTH));

   // Grant selection from current requests and state; nothing is granted while in reset.
   always_comb begin
      if_gnt_s = 1'b0;
      ld_gnt_s = 1'b0;
      if (rst) begin
         if_gnt_s = 1'b0;
      end else begin
         case (state_r)
            ST_ARB: begin
               // A pending lock withholds fetch so LOCK can be entered on the next edge.
               if (ld_lock) begin
                  ld_gnt_s = ld_req;
               end else if (ld_req && (starve_r == LIMIT)) begin
                  ld_gnt_s = 1'b1;
               end else if (if_req) begin
                  if_gnt_s = 1'b1;
               end else begin
                  ld_gnt_s = ld_req;
               end
            end
            ST_LOCK: ld_gnt_s = ld_req;
            default: begin
               if_gnt_s = 1'b0;
               ld_gnt_s = 1'b0;
            end
         endcase
      end
   end

   assign if_gnt    = if_gnt_s;
   assign ld_gnt    = ld_gnt_s;
   assign mem_en    = (if_gnt_s & if_inr_s) | (ld_gnt_s & ld_inr_s);
   assign mem_we    = ld_gnt_s & ld_we & ld_inr_s;
   assign mem_addr  = if_gnt_s ? if_word_s : (ld_gnt_s ? ld_word_s : {ALEN{1'b0}});
   assign mem_wdata = mem_we ? ld_wdata : {XLEN{1'b0}};

   // State, starvation counter and response-owner tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_ARB;
         owner_r  <= OWN_NONE;
         oor_r    <= 1'b0;
         wr_r     <= 1'b0;
         starve_r <= 4'd0;
      end else begin
         if (if_gnt_s) begin
            owner_r <= OWN_FETCH;
            oor_r   <= ~if_inr_s;
         end else if (ld_gnt_s) begin
            owner_r <= OWN_LOAD;
            oor_r   <= ~ld_inr_s;
         end else begin
            owner_r <= OWN_NONE;
            oor_r   <= 1'b0;
         end
         wr_r <= ld_gnt_s & ld_we;

         case (state_r)
            ST_ARB: begin
               if (!ld_req || ld_gnt_s) begin
                  starve_r <= 4'd0;
               end else if (starve_r < LIMIT) begin
                  starve_r <= starve_r + 4'd1;
               end else begin
                  starve_r <= starve_r;
               end
               if (ld_lock && !if_gnt_s) begin
                  state_r <= ST_LOCK;
               end else begin
                  state_r <= ST_ARB;
               end
            end
            ST_LOCK: begin
               starve_r <= 4'd0;
               if (!ld_lock && !ld_gnt_s) begin
                  state_r <= ST_ARB;
               end else begin
                  state_r <= ST_LOCK;
               end
            end
            default: begin
               state_r  <= ST_ARB;
               starve_r <= 4'd0;
            end
         endcase
      end
   end

   // Responses are gated by rst so an in-flight access never surfaces during reset.
   assign locked    = ~rst & (state_r == ST_LOCK);
   assign if_rvalid = ~rst & (owner_r == OWN_FETCH);
   assign ld_rvalid = ~rst & (owner_r == OWN_LOAD);
   assign if_rdata  = if_rvalid ? (oor_r ? NOP_INSN : mem_rdata) : {XLEN{1'b0}};
   assign ld_rdata  = ld_rvalid ? (wr_r ? {XLEN{1'b0}} : (oor_r ? NOP_INSN : mem_rdata))
                                : {XLEN{1'b0}};

`ifdef IMEM_ARB_PERF_EN
   logic [31:0] perf_if_grants_r;
   logic [31:0] perf_ld_grants_r;
   logic [31:0] perf_if_stall_r;

   // Saturating grant and fetch-stall counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_if_grants_r <= 32'd0;
         perf_ld_grants_r <= 32'd0;
         perf_if_stall_r  <= 32'd0;
      end else begin
         if (if_gnt_s && (perf_if_grants_r != {32{1'b1}})) begin
            perf_if_grants_r <= perf_if_grants_r + 32'd1;
         end else begin
            perf_if_grants_r <= perf_if_grants_r;
         end
         if (ld_gnt_s && (perf_ld_grants_r != {32{1'b1}})) begin
            perf_ld_grants_r <= perf_ld_grants_r + 32'd1;
         end else begin
            perf_ld_grants_r <= perf_ld_grants_r;
         end
         if (if_req && !if_gnt_s && (perf_if_stall_r != {32{1'b1}})) begin
            perf_if_stall_r <= perf_if_stall_r + 32'd1;
         end else begin
            perf_if_stall_r <= perf_if_stall_r;
         end
      end
   end

   assign perf_if_grants = perf_if_grants_r;
   assign perf_ld_grants = perf_ld_grants_r;
   assign perf_if_stall  = perf_if_stall_r;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 1-cycle synchronous memory array.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        ld_req;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_wdata;
   logic        ld_lock;
   logic        ld_gnt;
   logic        ld_rvalid;
   logic [31:0] ld_rdata;
   logic        locked;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
`ifdef IMEM_ARB_PERF_EN
   logic [31:0] perf_if_grants;
   logic [31:0] perf_ld_grants;
   logic [31:0] perf_if_stall;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem [0:1023];

   always #5 clk = ~clk;

   imem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_lock(ld_lock), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .locked(locked), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_PERF_EN
      , .perf_if_grants(perf_if_grants), .perf_ld_grants(perf_ld_grants),
      .perf_if_stall(perf_if_stall)
`endif
   );

   // Memory array: word i preloaded with A000_0000 | i while in reset.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
         mem_rdata <= mem[mem_addr[9:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic lreq,
                        input logic lwe, input logic [31:0] laddr, input logic [31:0] lwdata,
                        input logic llock);
      if_req = ireq; if_addr = iaddr;
      ld_req = lreq; ld_we = lwe; ld_addr = laddr; ld_wdata = lwdata; ld_lock = llock;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("rst_if_gnt", if_gnt, 1'b0);
      chk("rst_ld_gnt", ld_gnt, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      next();
      rst = 1'b0;
      mid();
      chk("rst_locked", locked, 1'b0);
      chk("rst_if_rvalid", if_rvalid, 1'b0);
      chk("rst_ld_rvalid", ld_rvalid, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      next();

      // Fetch-only stream
      drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("f0_gnt", if_gnt, 1'b1);
      chk("f0_mem_en", mem_en, 1'b1);
      chk("f0_mem_addr", mem_addr, 32'd0);
      chk("f0_mem_we", mem_we, 1'b0);
      next();
      drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("f1_mem_addr", mem_addr, 32'd1);
      chk("f1_rvalid", if_rvalid, 1'b1);
      chk("f1_rdata", if_rdata, 32'hA000_0000);
      next();
      drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("f2_mem_addr", mem_addr, 32'd2);
      chk("f2_rdata", if_rdata, 32'hA000_0001);
      next();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("f3_gnt", if_gnt, 1'b0);
      chk("f3_mem_en", mem_en, 1'b0);
      chk("f3_rdata", if_rdata, 32'hA000_0002);
      next();
      mid();
      chk("f4_rvalid", if_rvalid, 1'b0);
      next();

      // Contention: loader wins after four denied cycles
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
         mid();
         chk("cont_if_gnt", if_gnt, 1'b1);
         chk("cont_ld_wait", ld_gnt, 1'b0);
         next();
      end
      mid();
      chk("cont_ld_gnt", ld_gnt, 1'b1);
      chk("cont_if_held", if_gnt, 1'b0);
      chk("cont_mem_addr", mem_addr, 32'd4);
      chk("cont_if_rdata", if_rdata, 32'hA000_0008);
      next();
      drive(1'b1, 32'h24, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      mid();
      chk("cont_ld_rvalid", ld_rvalid, 1'b1);
      chk("cont_ld_rdata", ld_rdata, 32'hA000_0004);
      chk("cont_if_rvalid0", if_rvalid, 1'b0);
      chk("cont_starve_clr", if_gnt, 1'b1);
      chk("cont_ld_deny", ld_gnt, 1'b0);
      next();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("cont_if_rdata2", if_rdata, 32'hA000_0009);
      next();

      // Lock and load while fetch keeps requesting
      drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b1);
      mid();
      chk("l0_if_gnt", if_gnt, 1'b0);
      chk("l0_ld_gnt", ld_gnt, 1'b1);
      chk("l0_mem_we", mem_we, 1'b1);
      chk("l0_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("l0_locked", locked, 1'b0);
      next();
      drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h4, 32'h0000_0093, 1'b1);
      mid();
      chk("l1_locked", locked, 1'b1);
      chk("l1_if_gnt", if_gnt, 1'b0);
      chk("l1_ld_gnt", ld_gnt, 1'b1);
      chk("l1_ack", ld_rvalid, 1'b1);
      chk("l1_ack_data", ld_rdata, 32'h0);
      next();
      drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      mid();
      chk("l2_locked", locked, 1'b1);
      chk("l2_if_gnt", if_gnt, 1'b0);
      chk("l2_ack", ld_rvalid, 1'b1);
      next();
      drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("l3_locked", locked, 1'b1);
      chk("l3_if_gnt", if_gnt, 1'b0);
      chk("l3_ld_rvalid", ld_rvalid, 1'b0);
      next();
      mid();
      chk("l4_locked", locked, 1'b0);
      chk("l4_if_gnt", if_gnt, 1'b1);
      next();
      drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("l5_rdata", if_rdata, 32'hDEAD_BEEF);
      next();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("l6_rdata", if_rdata, 32'h0000_0093);
      next();

      // Out-of-range accesses
      drive(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("oor_if_gnt", if_gnt, 1'b1);
      chk("oor_if_mem_en", mem_en, 1'b0);
      next();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'h1234_5678, 1'b0);
      mid();
      chk("oor_if_nop", if_rdata, 32'h0000_0013);
      chk("oor_if_rvalid", if_rvalid, 1'b1);
      chk("oor_ld_gnt", ld_gnt, 1'b1);
      chk("oor_ld_mem_en", mem_en, 1'b0);
      chk("oor_ld_mem_we", mem_we, 1'b0);
      next();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b0);
      mid();
      chk("oor_wr_ack", ld_rvalid, 1'b1);
      chk("oor_wr_ack_data", ld_rdata, 32'h0);
      next();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("oor_ld_nop", ld_rdata, 32'h0000_0013);
      next();

      // Reset in the middle of a fetch
      drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("rm_gnt", if_gnt, 1'b1);
      next();
      rst = 1'b1;
      drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
      mid();
      chk("rm_if_rvalid", if_rvalid, 1'b0);
      chk("rm_if_gnt", if_gnt, 1'b0);
      chk("rm_ld_gnt", ld_gnt, 1'b0);
      chk("rm_mem_en", mem_en, 1'b0);
      chk("rm_if_rdata", if_rdata, 32'h0);
      next();
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("rm_after_rvalid", if_rvalid, 1'b0);
      chk("rm_after_locked", locked, 1'b0);
      next();

`ifdef IMEM_ARB_PERF_EN
      rst = 1'b1;
      next();
      rst = 1'b0;
      mid();
      chk("perf_clr_if", perf_if_grants, 32'd0);
      next();
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
         next();
      end
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
         next();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("perf_if_grants", perf_if_grants, 32'd10);
      chk("perf_ld_grants", perf_ld_grants, 32'd3);
      chk("perf_if_stall", perf_if_stall, 32'd3);
      next();
      rst = 1'b1;
      next();
      rst = 1'b0;
      mid();
      chk("perf_rst_if", perf_if_grants, 32'd0);
      chk("perf_rst_ld", perf_ld_grants, 32'd0);
      chk("perf_rst_stall", perf_if_stall, 32'd0);
      next();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Single-port arbiter/sequencer in front of the instruction memory array.
- Shares the array between the IF-stage fetch requester and the program-loader/debug requester, which reads and writes.
- Owns the 1-cycle synchronous memory port, routes read data back to the granted requester, and substitutes NOP (32'h00000013) for out-of-range reads.
- Provides a loader lock so a program image can be written while fetch is stalled.

Parameters:
ALEN, 32, address width in bits (byte address)
XLEN, 32, data/instruction width
DEPTH, 1024, memory depth in XLEN words
STARVE_LIMIT, 4, consecutive loader-denied cycles before loader is forced to win (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request
if_addr  in  ALEN  fetch byte address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid (1 cycle after if_gnt)
if_rdata  out  XLEN  fetch data
ld_req  in  1  loader request
ld_we  in  1  loader write (1) / read (0)
ld_addr  in  ALEN  loader byte address
ld_wdata  in  XLEN  loader write data
ld_lock  in  1  loader exclusive-ownership request
ld_gnt  out  1  loader accepted this cycle
ld_rvalid  out  1  loader read data valid / write ack (1 cycle after ld_gnt)
ld_rdata  out  XLEN  loader read data (0 on write ack)
locked  out  1  arbiter in LOCK state
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ALEN  word address to array (byte addr >> 2)
mem_wdata  out  XLEN  write data
mem_rdata  in  XLEN  array read data, valid the cycle after mem_en

Behaviour:
- Reset: all outputs 0; state=ARB; starve_cnt=0; owner=NONE.
- Grant is combinational from current request and state. At most one gnt per cycle; a gnt is always accompanied by mem_en=1, except for out-of-range accesses.
- Word address = addr >> 2; addr[1:0] ignored. In range iff word address < DEPTH.
- Out-of-range access:
  - Still granted; mem_en=0.
  - Read response 1 cycle later = 32'h00000013.
  - Write is dropped; ld_rvalid is still pulsed.
- Response: owner register captures the granted requester (and whether the access was out of range). Next cycle, exactly one of if_rvalid/ld_rvalid pulses with mem_rdata (or NOP / 0 for a write ack).
- Back-to-back grants are allowed every cycle; throughput is 1 access per cycle.
- State ARB:
  - Priority: if starve_cnt==STARVE_LIMIT and ld_req, grant loader. Otherwise grant fetch if if_req, else grant loader if ld_req.
  - starve_cnt: increments (saturating at STARVE_LIMIT) on each cycle ld_req=1 and ld_gnt=0; clears on ld_gnt or when ld_req=0.
  - Transition to LOCK when ld_lock=1 and no fetch response is pending (owner!=FETCH in next cycle). While waiting for that, fetch grants are withheld.
- State LOCK:
  - locked=1; if_gnt=0 regardless of if_req; loader granted every cycle ld_req=1.
  - Return to ARB when ld_lock=0 and no loader response is pending.
  - starve_cnt held at 0.
- Simultaneous events:
  - ld_lock rising while if_req=1 and a fetch response is in flight: that response completes; no new fetch grant.
  - ld_lock and ld_req in the same cycle as entering LOCK: the loader may be granted that cycle.
- Reset mid-operation: an in-flight response is discarded (no rvalid after reset); state returns to ARB.
- Requesters hold req/addr/data stable until gnt; the arbiter does not check this.

Optional Feature:
- Macro IMEM_ARB_PERF_EN.
- Defined: adds outputs perf_if_grants (32), perf_ld_grants (32) and perf_if_stall (32).
  - perf_if_stall counts cycles with if_req=1 and if_gnt=0.
  - All three counters saturate at all-ones and clear on rst.
- Undefined: no counters and no such ports; all other behaviour identical.

Test Plan:
- Fetch-only: if_req=1 with if_addr=0x0,0x4,0x8 on consecutive cycles -> if_gnt every cycle; mem_addr=0,1,2; if_rvalid next cycle with preloaded words.
- Contention: if_req and ld_req (read, 0x10) both held, STARVE_LIMIT=4 -> fetch granted cycles 0-3; loader granted cycle 4; ld_rvalid cycle 5 with word 4; starve_cnt back to 0.
- Lock/load: ld_lock=1, writes of 0xDEADBEEF to 0x0 and 0x00000093 to 0x4 while if_req=1 -> locked=1, if_gnt=0 throughout, two write acks. Then ld_lock=0 -> fetch of 0x0 returns 0xDEADBEEF.
- Out of range: DEPTH=1024, if_addr=0x1000 -> if_gnt=1, mem_en=0, if_rdata=0x00000013 next cycle. Loader write to 0x2000 -> dropped, ld_rvalid pulsed, memory unchanged.
- Reset mid-access: fetch granted, rst=1 next cycle -> if_rvalid stays 0; all outputs 0; state ARB.
- IMEM_ARB_PERF_EN: 10 fetch grants, 3 loader grants, 3 fetch stall cycles -> counters read 10/3/3; rst clears all to 0.
